// File: rtl/regfile_pkg.sv
// Shared constants for the ID-stage register file: load-mode encodings and default sizes.
package regfile_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned NREGS_DEF  = 32;

    localparam logic [2:0] LM_WORD   = 3'b000;
    localparam logic [2:0] LM_HALF_U = 3'b001;
    localparam logic [2:0] LM_HALF_S = 3'b010;
    localparam logic [2:0] LM_BYTE_U = 3'b011;
    localparam logic [2:0] LM_BYTE_S = 3'b100;

endpackage

// File: rtl/load_extender.sv
// Narrows writeback data to word/half/byte with sign or zero fill; valid=0 for unused encodings.
module load_extender
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] data_in,
    input  logic [2:0]        mode,
    output logic [DATA_W-1:0] data_out,
    output logic              valid
);

    always_comb begin
        data_out = data_in;
        valid    = 1'b1;
        case (mode)
            LM_WORD:   data_out = data_in;
            LM_HALF_U: data_out = {{(DATA_W-16){1'b0}}, data_in[15:0]};
            LM_HALF_S: data_out = {{(DATA_W-16){data_in[15]}}, data_in[15:0]};
            LM_BYTE_U: data_out = {{(DATA_W-8){1'b0}}, data_in[7:0]};
            LM_BYTE_S: data_out = {{(DATA_W-8){data_in[7]}}, data_in[7:0]};
            default:   valid    = 1'b0;
        endcase
    end

endmodule

// File: rtl/id_regfile_scoreboard.sv
// ID-stage register file with pending-write scoreboard and RAW hazard detection.
// Optional same-cycle writeback forwarding is enabled by defining REGFILE_BYPASS_EN.
module id_regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned NREGS  = NREGS_DEF,
    parameter int unsigned ADDR_W = $clog2(NREGS),
    parameter int unsigned CNT_W  = $clog2(NREGS) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       instruction,
    input  logic              imm_sext,
    input  logic              rs_used,
    input  logic              rt_used,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_dst,
    output logic              issue_ready,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [2:0]        load_mode,
    input  logic              flush,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    output logic [DATA_W-1:0] ext_imm,
    output logic              hazard,
    output logic [CNT_W-1:0]  pend_cnt
);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [NREGS-1:0]  busy_q, busy_d;
    logic [CNT_W-1:0]  pend_cnt_q, pend_cnt_d;

    logic [ADDR_W-1:0] rs, rt;
    logic [DATA_W-1:0] wr_ext;
    logic              wr_ext_valid, wr_commit, issue_fire, set_new, clr_old;
    logic              rs_busy, rt_busy;
    logic              unused_instr_bits;

    assign rs                = instruction[21 +: ADDR_W];
    assign rt                = instruction[16 +: ADDR_W];
    assign unused_instr_bits = ^instruction[31:26];

    assign ext_imm = imm_sext ? {{(DATA_W-16){instruction[15]}}, instruction[15:0]}
                              : {{(DATA_W-16){1'b0}}, instruction[15:0]};

    load_extender #(
        .DATA_W (DATA_W)
    ) u_load_extender (
        .data_in  (wr_data),
        .mode     (load_mode),
        .data_out (wr_ext),
        .valid    (wr_ext_valid)
    );

    assign wr_commit = wr_en && (wr_addr != '0) && wr_ext_valid;

    always_comb begin
        read_data1 = (rs == '0) ? '0 : regs_q[rs];
        read_data2 = (rt == '0) ? '0 : regs_q[rt];
        rs_busy    = rs_used && (rs != '0) && busy_q[rs];
        rt_busy    = rt_used && (rt != '0) && busy_q[rt];
`ifdef REGFILE_BYPASS_EN
        // A retiring producer satisfies its consumer in the same cycle.
        if (wr_commit && (wr_addr == rs)) read_data1 = wr_ext;
        if (wr_commit && (wr_addr == rt)) read_data2 = wr_ext;
        if (wr_en && (wr_addr == rs)) rs_busy = 1'b0;
        if (wr_en && (wr_addr == rt)) rt_busy = 1'b0;
`endif
    end

    assign hazard      = rs_busy || rt_busy;
    assign issue_ready = !hazard;
    assign issue_fire  = issue_valid && issue_ready && (issue_dst != '0) && !flush;

    // Set wins over clear on the same register: the new producer is still outstanding.
    assign set_new = issue_fire && !busy_q[issue_dst];
    assign clr_old = wr_en && busy_q[wr_addr] && !(issue_fire && (issue_dst == wr_addr));

    always_comb begin
        busy_d = busy_q;
        if (wr_en)      busy_d[wr_addr]   = 1'b0;
        if (issue_fire) busy_d[issue_dst] = 1'b1;
        if (flush)      busy_d            = '0;
    end

    always_comb begin
        pend_cnt_d = pend_cnt_q;
        case ({set_new, clr_old})
            2'b10:   pend_cnt_d = pend_cnt_q + CNT_W'(1);
            2'b01:   pend_cnt_d = pend_cnt_q - CNT_W'(1);
            default: pend_cnt_d = pend_cnt_q;
        endcase
        if (flush) pend_cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
            busy_q     <= '0;
            pend_cnt_q <= '0;
        end else begin
            if (wr_commit) regs_q[wr_addr] <= wr_ext;
            busy_q     <= busy_d;
            pend_cnt_q <= pend_cnt_d;
        end
    end

    assign pend_cnt = pend_cnt_q;

endmodule

// File: tb/tb_id_regfile_scoreboard.sv
// Directed self-checking bench for id_regfile_scoreboard (either REGFILE_BYPASS_EN setting).
module tb_id_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction;
    logic        imm_sext, rs_used, rt_used;
    logic        issue_valid, issue_ready;
    logic [4:0]  issue_dst;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [2:0]  load_mode;
    logic        flush;
    logic [31:0] read_data1, read_data2, ext_imm;
    logic        hazard;
    logic [5:0]  pend_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    id_regfile_scoreboard dut (
        .clk         (clk),
        .reset       (reset),
        .instruction (instruction),
        .imm_sext    (imm_sext),
        .rs_used     (rs_used),
        .rt_used     (rt_used),
        .issue_valid (issue_valid),
        .issue_dst   (issue_dst),
        .issue_ready (issue_ready),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .load_mode   (load_mode),
        .flush       (flush),
        .read_data1  (read_data1),
        .read_data2  (read_data2),
        .ext_imm     (ext_imm),
        .hazard      (hazard),
        .pend_cnt    (pend_cnt)
    );

    function automatic logic [31:0] mk(input logic [4:0] rs_a, input logic [4:0] rt_a,
                                       input logic [15:0] imm);
        return {6'b0, rs_a, rt_a, imm};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d, input logic [2:0] m);
        wr_en = 1'b1; wr_addr = a; wr_data = d; load_mode = m;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic issue(input logic [4:0] d);
        issue_valid = 1'b1; issue_dst = d;
        tick();
        issue_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; instruction = '0; imm_sext = 1'b0; rs_used = 1'b0; rt_used = 1'b0;
        issue_valid = 1'b0; issue_dst = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        load_mode = 3'b000; flush = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;

        // 1: reset state
        for (int i = 0; i < 32; i++) begin
            instruction = mk(5'(i), 5'(31 - i), 16'h0);
            #1;
            check("rst_rd1", read_data1, 32'h0);
            check("rst_rd2", read_data2, 32'h0);
        end
        check("rst_pend", 32'(pend_cnt), 32'd0);
        check("rst_hazard", 32'(hazard), 32'd0);
        instruction = mk(5'd0, 5'd0, 16'h8001); imm_sext = 1'b1; #1;
        check("imm_sext", ext_imm, 32'hFFFF_8001);
        imm_sext = 1'b0; #1;
        check("imm_zext", ext_imm, 32'h0000_8001);

        // 2: load-mode extension
        instruction = mk(5'd5, 5'd0, 16'h0);
        write_reg(5'd5, 32'h0000_8001, 3'b010); #1;
        check("half_s", read_data1, 32'hFFFF_8001);
        write_reg(5'd5, 32'h0000_8001, 3'b001); #1;
        check("half_u", read_data1, 32'h0000_8001);
        write_reg(5'd5, 32'h0000_0080, 3'b100); #1;
        check("byte_s", read_data1, 32'hFFFF_FF80);
        write_reg(5'd5, 32'h1234_56F0, 3'b011); #1;
        check("byte_u", read_data1, 32'h0000_00F0);
        write_reg(5'd5, 32'hCAFE_BABE, 3'b000); #1;
        check("word", read_data1, 32'hCAFE_BABE);
        write_reg(5'd5, 32'h1111_1111, 3'b101); #1;
        check("bad_mode_nowr", read_data1, 32'hCAFE_BABE);

        // 3: RAW hazard on rs and rt, cleared by writeback
        issue(5'd7); #1;
        check("iss7_pend", 32'(pend_cnt), 32'd1);
        instruction = mk(5'd7, 5'd0, 16'h0); rs_used = 1'b1; #1;
        check("raw_hazard", 32'(hazard), 32'd1);
        check("raw_ready", 32'(issue_ready), 32'd0);
        rs_used = 1'b0;
        instruction = mk(5'd0, 5'd7, 16'h0); rt_used = 1'b1; #1;
        check("raw_rt_hazard", 32'(hazard), 32'd1);
        rt_used = 1'b0;
        instruction = mk(5'd7, 5'd0, 16'h0); rs_used = 1'b1;
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h1111_2222; load_mode = 3'b000; #1;
`ifdef REGFILE_BYPASS_EN
        check("wb_cyc_hazard", 32'(hazard), 32'd0);
        check("wb_cyc_rd1", read_data1, 32'h1111_2222);
`else
        check("wb_cyc_hazard", 32'(hazard), 32'd1);
        check("wb_cyc_rd1", read_data1, 32'h0);
`endif
        tick();
        wr_en = 1'b0; #1;
        check("post_wb_hazard", 32'(hazard), 32'd0);
        check("post_wb_rd1", read_data1, 32'h1111_2222);
        check("post_wb_pend", 32'(pend_cnt), 32'd0);
        rs_used = 1'b0;

        // 4: register zero
        issue(5'd0); #1;
        check("iss0_pend", 32'(pend_cnt), 32'd0);
        instruction = mk(5'd0, 5'd0, 16'h0); rs_used = 1'b1; #1;
        check("iss0_hazard", 32'(hazard), 32'd0);
        rs_used = 1'b0;
        write_reg(5'd0, 32'h0000_DEAD, 3'b000); #1;
        check("r0_read", read_data1, 32'h0);

        // 5: issue and retire same register same cycle; WAW issue
        issue(5'd3); #1;
        check("iss3_pend", 32'(pend_cnt), 32'd1);
        issue_valid = 1'b1; issue_dst = 5'd3;
        write_reg(5'd3, 32'h0000_0033, 3'b000);
        issue_valid = 1'b0;
        instruction = mk(5'd3, 5'd0, 16'h0); rs_used = 1'b1; #1;
        check("same_pend", 32'(pend_cnt), 32'd1);
        check("same_busy", 32'(hazard), 32'd1);
        check("same_data", read_data1, 32'h0000_0033);
        rs_used = 1'b0;
        issue(5'd3); #1;
        check("waw_pend", 32'(pend_cnt), 32'd1);
        issue_valid = 1'b1; issue_dst = 5'd10;
        write_reg(5'd3, 32'h0, 3'b000);
        issue_valid = 1'b0; #1;
        check("swap_pend", 32'(pend_cnt), 32'd1);
        write_reg(5'd10, 32'h0, 3'b000); #1;
        check("drain_pend", 32'(pend_cnt), 32'd0);

        // 6: flush and reset
        issue(5'd1);
        issue(5'd2);
        issue(5'd4); #1;
        check("three_pend", 32'(pend_cnt), 32'd3);
        instruction = mk(5'd1, 5'd4, 16'h0); rs_used = 1'b1; rt_used = 1'b1; #1;
        check("pre_flush_hz", 32'(hazard), 32'd1);
        rs_used = 1'b0; rt_used = 1'b0;
        flush = 1'b1; issue_valid = 1'b1; issue_dst = 5'd6;
        write_reg(5'd9, 32'h0000_0099, 3'b000);
        flush = 1'b0; issue_valid = 1'b0;
        instruction = mk(5'd9, 5'd6, 16'h0); rs_used = 1'b1; rt_used = 1'b1; #1;
        check("flush_pend", 32'(pend_cnt), 32'd0);
        check("flush_hazard", 32'(hazard), 32'd0);
        check("flush_wr_commit", read_data1, 32'h0000_0099);
        rs_used = 1'b0; rt_used = 1'b0;
        issue(5'd12);
        reset = 1'b1; issue_valid = 1'b1; issue_dst = 5'd13;
        write_reg(5'd9, 32'h0000_1234, 3'b000);
        reset = 1'b0; issue_valid = 1'b0; #1;
        check("rst_r9", read_data1, 32'h0);
        check("rst_pend2", 32'(pend_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
